// File: rtl/rd_burst_assembler.sv
// rtl/rd_burst_assembler.sv - pairs queued read commands with returning DQ rise/fall beat pairs
// Bounded in-order command FIFO plus a pair counter; one rd_valid pulse per completed burst.
module rd_burst_assembler #(
   parameter int DQ_W   = 8,
   parameter int ADDR_W = 29,
   parameter int DEPTH  = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                clock_t,
   input  logic                reset_n,
   input  logic                rd_cmd_valid,
   input  logic [ADDR_W-1:0]   rd_cmd_addr,
   input  logic                rd_cmd_bl4,
   output logic                cmd_ready,
   input  logic                dq_valid,
   input  logic [DQ_W-1:0]     dq_rise,
   input  logic [DQ_W-1:0]     dq_fall,
   output logic                rd_valid,
   output logic [ADDR_W-1:0]   rd_addr,
   output logic [8*DQ_W-1:0]   rd_data,
   output logic                rd_bl4,
   output logic [CW-1:0]       outstanding,
   output logic                err_orphan,
   output logic                err_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
   logic [DEPTH-1:0]  r_fifo_bl4;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [1:0]        r_pc;
   logic [8*DQ_W-1:0] r_stage;
   logic              r_rd_valid;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [8*DQ_W-1:0] r_rd_data;
   logic              r_rd_bl4;
   logic              r_err_orphan;
   logic              r_err_overflow;

   logic              w_empty;
   logic              w_beat;
   logic              w_head_bl4;
   logic              w_last;
   logic              w_pop;
   logic              w_ready;
   logic              w_push;
   logic [8*DQ_W-1:0] w_merged;
   logic [8*DQ_W-1:0] w_out_data;

   assign w_empty    = (r_count == '0);
   assign w_beat     = dq_valid && !w_empty;
   assign w_head_bl4 = r_fifo_bl4[r_rd_ptr];
   assign w_last     = w_head_bl4 ? (r_pc == 2'd1) : (r_pc == 2'd3);
   assign w_pop      = w_beat && w_last;
   // A completing burst frees its slot in the same cycle, so a full FIFO can still accept.
   assign w_ready    = (r_count < C_DEPTH) || w_pop;
   assign w_push     = rd_cmd_valid && w_ready;

   always_comb begin
      w_merged = r_stage;
      for (int i = 0; i < 4; i++) begin
         if (r_pc == 2'(i)) begin
            w_merged[i*2*DQ_W +: 2*DQ_W] = {dq_fall, dq_rise};
         end
      end
      w_out_data = w_merged;
      if (w_head_bl4) begin
         w_out_data[8*DQ_W-1:4*DQ_W] = '0;
      end
   end

   always_ff @(posedge clock_t) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= rd_cmd_addr;
         r_fifo_bl4[r_wr_ptr]  <= rd_cmd_bl4;
      end
   end

   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_pc           <= '0;
         r_stage        <= '0;
         r_rd_valid     <= 1'b0;
         r_rd_addr      <= '0;
         r_rd_data      <= '0;
         r_rd_bl4       <= 1'b0;
         r_err_orphan   <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         // Staging is wiped on completion so a following BC4 never carries old upper beats.
         if (w_pop) begin
            r_pc    <= '0;
            r_stage <= '0;
         end else if (w_beat) begin
            r_pc    <= r_pc + 1'b1;
            r_stage <= w_merged;
         end

         r_rd_valid <= w_pop;
         if (w_pop) begin
            r_rd_addr <= r_fifo_addr[r_rd_ptr];
            r_rd_data <= w_out_data;
            r_rd_bl4  <= w_head_bl4;
         end

         if (dq_valid && w_empty) begin
            r_err_orphan <= 1'b1;
         end
         if (rd_cmd_valid && !w_ready) begin
            r_err_overflow <= 1'b1;
         end
      end
   end

   assign cmd_ready    = w_ready;
   assign rd_valid     = r_rd_valid;
   assign rd_addr      = r_rd_addr;
   assign rd_data      = r_rd_data;
   assign rd_bl4       = r_rd_bl4;
   assign outstanding  = r_count;
   assign err_orphan   = r_err_orphan;
   assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_rd_burst_assembler.sv
// tb/tb_rd_burst_assembler.sv - self-checking bench for rd_burst_assembler
// Queue-based reference model predicts every cycle's outputs from the command/beat rules.
module tb_rd_burst_assembler;

   localparam int DQ_W   = 8;
   localparam int ADDR_W = 29;
   localparam int DEPTH  = 8;
   localparam int CW     = $clog2(DEPTH + 1);

   logic                clock_t = 1'b0;
   logic                reset_n;
   logic                rd_cmd_valid;
   logic [ADDR_W-1:0]   rd_cmd_addr;
   logic                rd_cmd_bl4;
   logic                cmd_ready;
   logic                dq_valid;
   logic [DQ_W-1:0]     dq_rise;
   logic [DQ_W-1:0]     dq_fall;
   logic                rd_valid;
   logic [ADDR_W-1:0]   rd_addr;
   logic [8*DQ_W-1:0]   rd_data;
   logic                rd_bl4;
   logic [CW-1:0]       outstanding;
   logic                err_orphan;
   logic                err_overflow;

   always #5 clock_t = ~clock_t;

   rd_burst_assembler #(.DQ_W(DQ_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clock_t      (clock_t),
      .reset_n      (reset_n),
      .rd_cmd_valid (rd_cmd_valid),
      .rd_cmd_addr  (rd_cmd_addr),
      .rd_cmd_bl4   (rd_cmd_bl4),
      .cmd_ready    (cmd_ready),
      .dq_valid     (dq_valid),
      .dq_rise      (dq_rise),
      .dq_fall      (dq_fall),
      .rd_valid     (rd_valid),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_bl4       (rd_bl4),
      .outstanding  (outstanding),
      .err_orphan   (err_orphan),
      .err_overflow (err_overflow)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              bl4;
   } cmd_t;

   cmd_t              mq[$];
   logic [7:0]        m_beats[8];
   int                m_pairs;
   logic              m_valid;
   logic [ADDR_W-1:0] m_addr;
   logic [63:0]       m_data;
   logic              m_bl4;
   logic              m_orphan;
   logic              m_overflow;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_pairs = 0;
      for (int i = 0; i < 8; i++) m_beats[i] = '0;
      m_valid    = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      m_bl4      = 1'b0;
      m_orphan   = 1'b0;
      m_overflow = 1'b0;
   endtask

   task automatic check_regs();
      chk("rd_valid",     64'(rd_valid),     64'(m_valid));
      chk("rd_addr",      64'(rd_addr),      64'(m_addr));
      chk("rd_data",      64'(rd_data),      m_data);
      chk("rd_bl4",       64'(rd_bl4),       64'(m_bl4));
      chk("outstanding",  64'(outstanding),  64'(mq.size()));
      chk("err_orphan",   64'(err_orphan),   64'(m_orphan));
      chk("err_overflow", 64'(err_overflow), 64'(m_overflow));
   endtask

   task automatic drive_idle_inputs();
      rd_cmd_valid = 1'b0;
      rd_cmd_addr  = '0;
      rd_cmd_bl4   = 1'b0;
      dq_valid     = 1'b0;
      dq_rise      = '0;
      dq_fall      = '0;
   endtask

   task automatic do_reset();
      @(posedge clock_t);
      #3;
      drive_idle_inputs();
      reset_n = 1'b0;
      model_reset();
      #1;
      check_regs();
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clock_t);
      #3;
      reset_n = 1'b1;
      @(posedge clock_t);
      #1;
   endtask

   // One clock of stimulus; the model applies the same cycle's rules before the edge.
   task automatic cycle(input logic cv, input logic [ADDR_W-1:0] ca, input logic cb,
                        input logic dv, input logic [7:0] dr, input logic [7:0] df);
      int   sz0;
      logic pop;
      logic ready;
      rd_cmd_valid = cv;
      rd_cmd_addr  = ca;
      rd_cmd_bl4   = cb;
      dq_valid     = dv;
      dq_rise      = dr;
      dq_fall      = df;
      sz0     = mq.size();
      pop     = 1'b0;
      m_valid = 1'b0;
      if (dv) begin
         if (sz0 == 0) begin
            m_orphan = 1'b1;
         end else begin
            m_beats[2*m_pairs]   = dr;
            m_beats[2*m_pairs+1] = df;
            m_pairs++;
            if (m_pairs == (mq[0].bl4 ? 2 : 4)) begin
               pop     = 1'b1;
               m_valid = 1'b1;
               m_addr  = mq[0].addr;
               m_bl4   = mq[0].bl4;
               m_data  = '0;
               for (int i = 0; i < 8; i++) m_data = m_data | (64'(m_beats[i]) << (8*i));
               void'(mq.pop_front());
               m_pairs = 0;
               for (int i = 0; i < 8; i++) m_beats[i] = '0;
            end
         end
      end
      ready = (sz0 < DEPTH) || pop;
      if (cv) begin
         if (ready) mq.push_back(cmd_t'{addr: ca, bl4: cb});
         else       m_overflow = 1'b1;
      end
      #1;
      chk("cmd_ready", 64'(cmd_ready), 64'(ready));
      @(posedge clock_t);
      #1;
      check_regs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 8'h0, 8'h0);
   endtask

   task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic b);
      cycle(1'b1, a, b, 1'b0, 8'h0, 8'h0);
   endtask

   task automatic pair(input logic [7:0] r, input logic [7:0] f);
      cycle(1'b0, '0, 1'b0, 1'b1, r, f);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (mq.size() > 0 && guard < 1000) begin
         pair(8'($urandom), 8'($urandom));
         guard++;
      end
      chk("drain_bound", 64'(mq.size()), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      drive_idle_inputs();
      model_reset();

      // Reset values
      do_reset();

      // BL8 read at 0x10
      send_cmd(29'h10, 1'b0);
      pair(8'h01, 8'h02);
      pair(8'h03, 8'h04);
      pair(8'h05, 8'h06);
      pair(8'h07, 8'h08);
      chk("t1_valid", 64'(rd_valid), 64'd1);
      chk("t1_addr",  64'(rd_addr),  64'h10);
      chk("t1_data",  rd_data,       64'h0807060504030201);
      chk("t1_bl4",   64'(rd_bl4),   64'd0);
      idle(1);
      chk("t1_pulse_end", 64'(rd_valid), 64'd0);

      // BC4 read at 0x1ABCDEF
      send_cmd(29'h1ABCDEF, 1'b1);
      pair(8'hAA, 8'hBB);
      pair(8'hCC, 8'hDD);
      chk("t2_valid", 64'(rd_valid), 64'd1);
      chk("t2_addr",  64'(rd_addr),  64'h1ABCDEF);
      chk("t2_data",  rd_data,       64'h00000000DDCCBBAA);
      chk("t2_bl4",   64'(rd_bl4),   64'd1);

      // Fill to DEPTH, overflow attempt, then in-order bursts with gaps in burst 3
      for (int a = 0; a < DEPTH; a++) send_cmd(29'(a), 1'b0);
      cycle(1'b1, 29'h1FF, 1'b0, 1'b0, 8'h0, 8'h0);
      chk("t3_ready_full", 64'(cmd_ready),    64'd0);
      chk("t3_overflow",   64'(err_overflow), 64'd1);
      chk("t3_outst",      64'(outstanding),  64'd8);
      for (int b = 0; b < DEPTH; b++) begin
         for (int p = 0; p < 4; p++) begin
            if (b == 3 && p > 0) idle(2);
            pair(8'($urandom), 8'($urandom));
         end
         chk("t3_pulse", 64'(rd_valid), 64'd1);
         chk("t3_order", 64'(rd_addr),  64'(b));
      end

      // Orphan data with an empty FIFO, then a normal read
      do_reset();
      pair(8'h11, 8'h22);
      pair(8'h33, 8'h44);
      chk("t4_orphan", 64'(err_orphan),  64'd1);
      chk("t4_novalid", 64'(rd_valid),   64'd0);
      chk("t4_outst",  64'(outstanding), 64'd0);
      send_cmd(29'h123, 1'b0);
      for (int p = 0; p < 4; p++) pair(8'($urandom), 8'($urandom));
      chk("t4_valid", 64'(rd_valid), 64'd1);
      chk("t4_addr",  64'(rd_addr),  64'h123);

      // Push on a full FIFO in the same cycle as a completion
      do_reset();
      for (int a = 0; a < DEPTH; a++) send_cmd(29'(8'h40 + a), 1'b0);
      for (int p = 0; p < 3; p++) pair(8'($urandom), 8'($urandom));
      cycle(1'b1, 29'h99, 1'b0, 1'b1, 8'h5A, 8'hA5);
      chk("t5_valid",    64'(rd_valid),     64'd1);
      chk("t5_addr",     64'(rd_addr),      64'h40);
      chk("t5_outst",    64'(outstanding),  64'd8);
      chk("t5_no_ovf",   64'(err_overflow), 64'd0);
      drain();
      chk("t5_last_addr", 64'(rd_addr), 64'h99);

      // Reset mid-BL8, then a BC4 at 0x5
      do_reset();
      send_cmd(29'h20, 1'b0);
      pair(8'h10, 8'h20);
      pair(8'h30, 8'h40);
      do_reset();
      chk("t6_no_pulse", 64'(rd_valid), 64'd0);
      send_cmd(29'h5, 1'b1);
      pair(8'h61, 8'h62);
      pair(8'h63, 8'h64);
      chk("t6_valid", 64'(rd_valid),       64'd1);
      chk("t6_addr",  64'(rd_addr),        64'h5);
      chk("t6_upper", 64'(rd_data[63:32]), 64'd0);
      chk("t6_data",  rd_data,             64'h0000000064636261);
      idle(1);
      chk("t6_outst", 64'(outstanding), 64'd0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic cv;
         logic dv;
         cv = ($urandom_range(0, 3) == 0);
         if (mq.size() > 0) dv = ($urandom_range(0, 2) != 0);
         else               dv = ($urandom_range(0, 19) == 0);
         cycle(cv, 29'($urandom), 1'($urandom), dv, 8'($urandom), 8'($urandom));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
